// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared constants, types and helpers for the PDM-to-PCM CIC decimator.
//
// Configuration macro: PDM_DC_BLOCK_EN
//   When defined, each channel adds a DC-blocking stage. That stage costs one
//   extra pipeline cycle, so PIPE_LEN below grows by one.
// -----------------------------------------------------------------------------
package pdm_pkg;

    localparam int CIC_ORDER = 3;   // integrator / comb stages per channel
    localparam int CIC_W     = 19;  // CIC datapath width, wraps modulo 2^19
    localparam int PCM_W     = 16;  // output sample width
    localparam int DCB_SHIFT = 8;   // DC blocker pole: y -= y >>> 8
    localparam int DCB_W     = 24;  // DC blocker state width, 8 fractional bits

    typedef logic signed [CIC_W-1:0] cic_word_t;
    typedef logic signed [PCM_W-1:0] pcm_word_t;

    // Decimation strobe pipeline: one tap per comb stage, an optional DC
    // blocker tap, and a final tap that loads the output register.
`ifdef PDM_DC_BLOCK_EN
    localparam int PIPE_LEN = CIC_ORDER + 2;
`else
    localparam int PIPE_LEN = CIC_ORDER + 1;
`endif

    // Saturate a DC blocker sized value to the PCM range. The value fits
    // exactly when all bits above the PCM sign bit copy that sign bit.
    function automatic pcm_word_t sat_pcm(input logic signed [DCB_W-1:0] v);
        logic [DCB_W-PCM_W:0] top;
        top = v[DCB_W-1:PCM_W-1];
        if ((&top) || !(|top)) begin
            return v[PCM_W-1:0];
        end else if (v[DCB_W-1]) begin
            return {1'b1, {(PCM_W-1){1'b0}}};
        end else begin
            return {1'b0, {(PCM_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator_if
// Stereo PCM sample bus with a valid/ready handshake.
//   Sample_ready : consumer -> decimator, the consumer takes the current pair
//   Left_sample  : decimator -> consumer, signed PCM, left channel
//   Right_sample : decimator -> consumer, signed PCM, right channel
//   Sample_valid : decimator -> consumer, the sample pair is valid
//   Overrun      : decimator -> consumer, sticky "sample overwritten" flag
// master = decimator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pdm_cic_decimator_if;
    import pdm_pkg::*;

    logic      Sample_ready;
    pcm_word_t Left_sample;
    pcm_word_t Right_sample;
    logic      Sample_valid;
    logic      Overrun;

    modport master (
        input  Sample_ready,
        output Left_sample, Right_sample, Sample_valid, Overrun
    );

    modport slave (
        output Sample_ready,
        input  Left_sample, Right_sample, Sample_valid, Overrun
    );

endinterface

// File: rtl/pdm_cic_channel.sv
// -----------------------------------------------------------------------------
// pdm_cic_channel
// One PDM channel: 3 integrators, 3 combs, output scaling and, when
// PDM_DC_BLOCK_EN is defined, a first-order DC blocker.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   i_int_en   : advance the integrators by one PDM bit
//   i_bit      : PDM bit for this update (1 -> +1, 0 -> -1)
//   i_stage_en : one-hot walking strobe; bit k runs comb stage k, and bit
//                CIC_ORDER (DC blocker builds only) runs the DC blocker
//   o_sample   : scaled sample; stable by the time the top level loads it
// -----------------------------------------------------------------------------
module pdm_cic_channel
    import pdm_pkg::*;
#(
    parameter int OUT_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_int_en,
    input  logic                i_bit,
    input  logic [PIPE_LEN-2:0] i_stage_en,
    output pcm_word_t           o_sample
);

    cic_word_t r_int      [CIC_ORDER];
    cic_word_t r_comb     [CIC_ORDER];
    cic_word_t r_comb_dly [CIC_ORDER];
    cic_word_t w_comb_in  [CIC_ORDER];
    cic_word_t w_step;
    pcm_word_t w_scaled;

    assign w_step = i_bit ? cic_word_t'(1) : cic_word_t'(-1);

    // Integrators wrap modulo 2^CIC_W on purpose. The combs remove the wrap
    // because the true output always fits in CIC_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these arrays are ordinary flops, not RAM, so they are
            // cleared in the reset branch like any other register.
            for (int k = 0; k < CIC_ORDER; k++) begin
                r_int[k] <= '0;
            end
        end else if (i_int_en) begin
            // NOTE: non-blocking assignments, so every stage adds the value
            // its upstream stage held before this edge.
            r_int[0] <= r_int[0] + w_step;
            for (int k = 1; k < CIC_ORDER; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
            end
        end
    end

    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch results.
        w_comb_in[0] = r_int[CIC_ORDER-1];
        for (int k = 1; k < CIC_ORDER; k++) begin
            w_comb_in[k] = r_comb[k-1];
        end
    end

    // Comb stage k runs one cycle after stage k-1 because it follows the
    // walking strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                r_comb[k]     <= '0;
                r_comb_dly[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CIC_ORDER; k++) begin
                if (i_stage_en[k]) begin
                    r_comb[k]     <= w_comb_in[k] - r_comb_dly[k];
                    r_comb_dly[k] <= w_comb_in[k];
                end
            end
        end
    end

    // Full scale is +/-R^3 = +/-125000, which becomes +/-31250 after the
    // shift, so the 16-bit truncation cannot wrap for R = 50.
    assign w_scaled = PCM_W'(r_comb[CIC_ORDER-1] >>> OUT_SHIFT);

`ifdef PDM_DC_BLOCK_EN
    // y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), with y in Q16.8.
    // Two guard bits hold the worst-case sum before it saturates back to
    // DCB_W bits.
    localparam int ACC_W = DCB_W + 2;

    pcm_word_t               r_dcb_x;
    logic signed [DCB_W-1:0] r_dcb_y;
    pcm_word_t               r_dcb_out;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [DCB_W-1:0] w_y_next;

    always_comb begin
        w_acc    = (ACC_W'(w_scaled) - ACC_W'(r_dcb_x)) <<< DCB_SHIFT;
        w_acc    = w_acc + ACC_W'(r_dcb_y) - ACC_W'(r_dcb_y >>> DCB_SHIFT);
        w_y_next = w_acc[DCB_W-1:0];
        if (!((&w_acc[ACC_W-1:DCB_W-1]) || !(|w_acc[ACC_W-1:DCB_W-1]))) begin
            w_y_next = w_acc[ACC_W-1] ? {1'b1, {(DCB_W-1){1'b0}}}
                                      : {1'b0, {(DCB_W-1){1'b1}}};
        end
    end

    // The arithmetic shift drops the fraction, which rounds toward -inf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcb_x   <= '0;
            r_dcb_y   <= '0;
            r_dcb_out <= '0;
        end else if (i_stage_en[CIC_ORDER]) begin
            r_dcb_x   <= w_scaled;
            r_dcb_y   <= w_y_next;
            r_dcb_out <= sat_pcm(w_y_next >>> DCB_SHIFT);
        end
    end

    assign o_sample = r_dcb_out;
`else
    assign o_sample = w_scaled;
`endif

endmodule

// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
// Converts two 1-bit PDM streams to 16-bit stereo PCM with one 3rd-order CIC
// decimator per channel. Decimation is by DECIMATION.
//   Clock_100MHz  : system clock, the only clock in the block
//   Reset_n       : asynchronous active-low reset
//   CLK           : PDM bit clock; it is sampled as data, never used as a clock
//   Left_channel  : PDM bit; changes on the falling edge of CLK
//   Right_channel : PDM bit; changes on the rising edge of CLK
//   pcm           : sample bus (valid/ready, samples, sticky Overrun)
// Parameters: DECIMATION (R), OUT_SHIFT (right shift before 16-bit truncation).
// Macro PDM_DC_BLOCK_EN adds a DC blocker and one cycle of latency.
// -----------------------------------------------------------------------------
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int DECIMATION = 50,
    parameter int OUT_SHIFT  = 2
) (
    input  logic                Clock_100MHz,
    input  logic                Reset_n,
    input  logic                CLK,
    input  logic                Left_channel,
    input  logic                Right_channel,
    pdm_cic_decimator_if.master pcm
);

    localparam int             CNT_W    = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

    logic                r_clk_meta;
    logic                r_clk_sync;
    logic                r_clk_prev;
    logic                r_l_bit;
    logic                r_r_bit;
    logic                r_int_en;
    logic [CNT_W-1:0]    r_dec_cnt;
    logic [PIPE_LEN-1:0] r_pipe;
    pcm_word_t           r_left_sample;
    pcm_word_t           r_right_sample;
    logic                r_valid;
    logic                r_overrun;

    logic                w_rise;
    logic                w_fall;
    logic                w_dec_wrap;
    logic                w_load;
    pcm_word_t           w_left;
    pcm_word_t           w_right;

    assign w_rise = r_clk_sync & ~r_clk_prev;
    assign w_fall = ~r_clk_sync & r_clk_prev;

    // Each channel is captured mid-bit, half a period away from its own data
    // transition. The integrators step one cycle after the rise, so they
    // use the fresh left bit and the right bit captured at the last fall.
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_clk_meta <= 1'b0;
            r_clk_sync <= 1'b0;
            r_clk_prev <= 1'b0;
            r_l_bit    <= 1'b0;
            r_r_bit    <= 1'b0;
            r_int_en   <= 1'b0;
        end else begin
            r_clk_meta <= CLK;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            if (w_fall) r_r_bit <= Right_channel;
            if (w_rise) r_l_bit <= Left_channel;
            r_int_en   <= w_rise;
        end
    end

    // Counts integrator updates. The wrap on the last update starts the comb
    // pipeline one cycle later, after the integrators have settled.
    assign w_dec_wrap = r_int_en && (r_dec_cnt == CNT_LAST);

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_dec_cnt <= '0;
            r_pipe    <= '0;
        end else begin
            if (r_int_en) begin
                r_dec_cnt <= (r_dec_cnt == CNT_LAST) ? '0 : r_dec_cnt + 1'b1;
            end
            // r_pipe[0] is dec_stb. Each later tap runs the next stage, and
            // the last tap loads the output register.
            r_pipe <= {r_pipe[PIPE_LEN-2:0], w_dec_wrap};
        end
    end

    pdm_cic_channel #(.OUT_SHIFT(OUT_SHIFT)) u_left (
        .clk        (Clock_100MHz),
        .rst_n      (Reset_n),
        .i_int_en   (r_int_en),
        .i_bit      (r_l_bit),
        .i_stage_en (r_pipe[PIPE_LEN-2:0]),
        .o_sample   (w_left)
    );

    pdm_cic_channel #(.OUT_SHIFT(OUT_SHIFT)) u_right (
        .clk        (Clock_100MHz),
        .rst_n      (Reset_n),
        .i_int_en   (r_int_en),
        .i_bit      (r_r_bit),
        .i_stage_en (r_pipe[PIPE_LEN-2:0]),
        .o_sample   (w_right)
    );

    // A new sample always loads. It counts as an overrun only when the held
    // sample is still unaccepted in that same cycle.
    assign w_load = r_pipe[PIPE_LEN-1];

    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_valid        <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (w_load) begin
            r_left_sample  <= w_left;
            r_right_sample <= w_right;
            r_valid        <= 1'b1;
            if (r_valid && !pcm.Sample_ready) r_overrun <= 1'b1;
        end else if (r_valid && pcm.Sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign pcm.Left_sample  = r_left_sample;
    assign pcm.Right_sample = r_right_sample;
    assign pcm.Sample_valid = r_valid;
    assign pcm.Overrun      = r_overrun;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_pdm_cic_decimator
// Self-checking bench for pdm_cic_decimator in its default build
// (PDM_DC_BLOCK_EN undefined). A front-end model drives CLK with a 42-cycle
// period (21 high / 21 low). Left_channel changes on CLK falling edges and
// Right_channel changes on CLK rising edges.
// -----------------------------------------------------------------------------
module tb_pdm_cic_decimator;
    import pdm_pkg::*;

    localparam int FULL = 31250;   // R^3 >> 2 for R = 50
    localparam int HALF = 21;      // system cycles per PDM half period

    typedef enum logic [1:0] {M_ONE, M_ZERO, M_ALT} mode_e;

    typedef struct {
        mode_e l_mode;
        mode_e r_mode;
        int    l_lo, l_hi;
        int    r_lo, r_hi;
    } vec_t;

    typedef struct {
        int l_lo, l_hi;
        int r_lo, r_hi;
    } exp_t;

    logic  clk     = 1'b0;
    logic  rst_n   = 1'b0;
    logic  pdm_clk = 1'b0;
    logic  left    = 1'b0;
    logic  right   = 1'b0;

    mode_e l_mode   = M_ONE;
    mode_e r_mode   = M_ONE;
    logic  l_alt    = 1'b0;
    int    ph       = 0;
    int    rise_cnt = 0;
    int    rise_base = 0;

    int    total = 0;
    int    bad   = 0;
    exp_t  sb_q[$];

    pdm_cic_decimator_if ifc ();

    pdm_cic_decimator dut (
        .Clock_100MHz  (clk),
        .Reset_n       (rst_n),
        .CLK           (pdm_clk),
        .Left_channel  (left),
        .Right_channel (right),
        .pcm           (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic mode_bit(input mode_e m, input logic alt);
        case (m)
            M_ONE:   return 1'b1;
            M_ZERO:  return 1'b0;
            default: return alt;
        endcase
    endfunction

    // Microphone front-end model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            if (ph == HALF) begin
                ph      = 0;
                pdm_clk = ~pdm_clk;
                if (pdm_clk) begin
                    rise_cnt++;
                    right = mode_bit(r_mode, 1'b0);
                end else begin
                    l_alt = ~l_alt;
                    left  = mode_bit(l_mode, l_alt);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " valid"},   int'(ifc.Sample_valid), 0, 0);
        check({tag, " left"},    int'(ifc.Left_sample),  0, 0);
        check({tag, " right"},   int'(ifc.Right_sample), 0, 0);
        check({tag, " overrun"}, int'(ifc.Overrun),      0, 0);
    endtask

    task automatic set_modes(input mode_e lm, input mode_e rm);
        l_mode = lm;
        r_mode = rm;
        left   = mode_bit(lm, l_alt);
        right  = mode_bit(rm, 1'b0);
    endtask

    // Pulses reset for 3 cycles while CLK is low and far from an edge, so
    // the first strobe after release is a genuine rise.
    task automatic rst_pulse(input bit chk, input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pdm_clk && ph == 5) break;
        end
        rst_n = 1'b0;
        #1;
        if (chk) check_zero_outputs(tag);
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        rise_base = rise_cnt;
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ifc.Sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: Sample_valid timeout, got 0, want 1", tag);
        end
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 10000 && rise_cnt < target; i++) @(negedge clk);
    endtask

    vec_t vecs[4];
    bit   ok;
    exp_t e;
    time  t0, t1;

    initial begin
        vecs[0] = '{M_ONE,  M_ZERO,  FULL,  FULL, -FULL, -FULL};
        vecs[1] = '{M_ZERO, M_ZERO, -FULL, -FULL, -FULL, -FULL};
        vecs[2] = '{M_ALT,  M_ONE,     -4,     4,  FULL,  FULL};
        vecs[3] = '{M_ONE,  M_ONE,   FULL,  FULL,  FULL,  FULL};

        ifc.Sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Steady-state vectors: samples 1-3 are the CIC transient and are
        // skipped. Samples 4 and 5 are scored.
        for (int v = 0; v < 4; v++) begin
            sb_q.delete();
            set_modes(vecs[v].l_mode, vecs[v].r_mode);
            for (int s = 4; s <= 5; s++) begin
                sb_q.push_back('{vecs[v].l_lo, vecs[v].l_hi, vecs[v].r_lo, vecs[v].r_hi});
            end
            rst_pulse(1'b0, "");
            for (int s = 1; s <= 5; s++) begin
                wait_valid($sformatf("vec%0d s%0d", v, s), ok);
                if (!ok) break;
                if (s >= 4) begin
                    e = sb_q.pop_front();
                    check($sformatf("vec%0d s%0d left", v, s),  int'(ifc.Left_sample),  e.l_lo, e.l_hi);
                    check($sformatf("vec%0d s%0d right", v, s), int'(ifc.Right_sample), e.r_lo, e.r_hi);
                end
            end
        end

        // Sample_ready held high: 1-cycle valid pulses 2100 cycles apart.
        wait_valid("pulse a", ok);
        t0 = $time;
        @(negedge clk);
        check("pulse width", int'(ifc.Sample_valid), 0, 0);
        wait_valid("pulse b", ok);
        t1 = $time;
        check("pulse period", int'((t1 - t0) / 10), 2100, 2100);
        check("no overrun", int'(ifc.Overrun), 0, 0);

        // Overrun: hold ready low, then switch both inputs to 0. The held
        // sample must be overwritten by later samples.
        @(negedge clk);
        ifc.Sample_ready = 1'b0;
        wait_valid("ovr first", ok);
        check("ovr first left",  int'(ifc.Left_sample),  FULL, FULL);
        check("ovr first right", int'(ifc.Right_sample), FULL, FULL);
        check("ovr first flag",  int'(ifc.Overrun), 0, 0);
        rise_base = rise_cnt;
        set_modes(M_ZERO, M_ZERO);
        wait_rises(rise_base + 50);
        repeat (15) @(negedge clk);
        check("ovr second flag",  int'(ifc.Overrun), 1, 1);
        check("ovr second valid", int'(ifc.Sample_valid), 1, 1);
        wait_rises(rise_base + 200);
        repeat (15) @(negedge clk);
        check("ovr held left",  int'(ifc.Left_sample),  -FULL, -FULL);
        check("ovr held right", int'(ifc.Right_sample), -FULL, -FULL);
        check("ovr held valid", int'(ifc.Sample_valid), 1, 1);
        ifc.Sample_ready = 1'b1;
        @(negedge clk);
        check("ovr accept drops valid", int'(ifc.Sample_valid), 0, 0);
        check("ovr sticky", int'(ifc.Overrun), 1, 1);

        // Reset in mid-decimation: outputs clear at once, and the next sample
        // follows exactly 50 rises after release.
        set_modes(M_ONE, M_ONE);
        wait_valid("mid wait", ok);
        wait_rises(rise_cnt + 20);
        rst_pulse(1'b1, "mid reset");
        wait_valid("mid first", ok);
        check("mid rises to valid", rise_cnt - rise_base, 50, 50);
        check("mid overrun after", int'(ifc.Overrun), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
